// File: rtl/fft_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_serializer
// Purpose  : Accepts one frame of four parallel complex samples ({real, imag},
//            signed Q16.16) per handshake, buffers up to two frames and emits
//            them one sample per cycle in output-index order. With REORDER=1
//            the slots are read bit-reversed (0,2,1,3).
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - frame handshake for in0..in3
//            in0..in3            - slot samples {real, imag}, 2*DATA_W each
//            out_valid/out_ready - per-sample handshake
//            out_real/out_imag   - split sample components, zero when idle
//            out_idx/out_last    - position k in frame, high on k == 3
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_serializer #(
  parameter int DATA_W  = 32,
  parameter bit REORDER = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in0,
  input  logic [2*DATA_W-1:0] in1,
  input  logic [2*DATA_W-1:0] in2,
  input  logic [2*DATA_W-1:0] in3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_real,
  output logic [DATA_W-1:0]   out_imag,
  output logic [1:0]          out_idx,
  output logic                out_last
);

  localparam int SAMPLE_W = 2 * DATA_W;

  // Two frame buffers of four slots; contents are never reset, only pointers.
  logic [SAMPLE_W-1:0] frame_q [2][4];

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q,  count_d;
  logic [1:0] k_q,      k_d;

  logic                accept;
  logic                pop;
  logic                pop_last;
  logic [1:0]          slot;
  logic [SAMPLE_W-1:0] sample;

  // Both handshake flags derive from registered occupancy only, so there is
  // no combinational path from out_ready to in_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);

  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign pop_last = pop && (k_q == 2'd3);

  generate
    if (REORDER) begin : g_bitrev
      // Bit-reversing a 2-bit index yields the 0,2,1,3 slot order.
      assign slot = {k_q[0], k_q[1]};
    end else begin : g_linear
      assign slot = k_q;
    end
  endgenerate

  assign sample = frame_q[rd_ptr_q][slot];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    k_d      = k_q;
    count_d  = count_q;

    if (accept) begin
      wr_ptr_d = ~wr_ptr_q;
    end

    if (pop) begin
      k_d = k_q + 2'd1;             // wraps 3 -> 0 naturally
      if (pop_last) begin
        rd_ptr_d = ~rd_ptr_q;
      end
    end

    // Only a final-word pop releases a frame; a simultaneous accept cancels it.
    case ({accept, pop_last})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      k_q      <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      k_q      <= k_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      frame_q[wr_ptr_q][0] <= in0;
      frame_q[wr_ptr_q][1] <= in1;
      frame_q[wr_ptr_q][2] <= in2;
      frame_q[wr_ptr_q][3] <= in3;
    end
  end

  // Outputs are forced to zero whenever no sample is presented.
  assign out_real = out_valid ? sample[SAMPLE_W-1:DATA_W] : '0;
  assign out_imag = out_valid ? sample[DATA_W-1:0]        : '0;
  assign out_idx  = out_valid ? k_q                       : 2'd0;
  assign out_last = out_valid && (k_q == 2'd3);

endmodule
`default_nettype wire
